// File: rtl/regfile_dbg_pkg.sv
// Shared opcode constants and FSM state encoding for the register-file debug port.
package regfile_dbg_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_CLEAR,
    ST_RESP
  } dbg_state_t;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug access controller for the integer register file: read / write / clear-all
// commands share the write port and read port 1 with the core, core writeback first.
module regfile_debug_port
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_wEn,
  input  logic [REG_SEL_BITS-1:0] core_write_sel,
  input  logic [DATA_WIDTH-1:0]   core_write_data,
  input  logic [REG_SEL_BITS-1:0] core_read1_sel,
  input  logic                    dbg_req_valid,
  output logic                    dbg_req_ready,
  input  logic [1:0]              dbg_req_op,
  input  logic [REG_SEL_BITS-1:0] dbg_req_sel,
  input  logic [DATA_WIDTH-1:0]   dbg_req_data,
  output logic                    dbg_rsp_valid,
  input  logic                    dbg_rsp_ready,
  output logic [DATA_WIDTH-1:0]   dbg_rsp_data,
  output logic                    dbg_rsp_err,
  output logic                    rf_wEn,
  output logic [REG_SEL_BITS-1:0] rf_write_sel,
  output logic [DATA_WIDTH-1:0]   rf_write_data,
  output logic [REG_SEL_BITS-1:0] rf_read1_sel,
  input  logic [DATA_WIDTH-1:0]   rf_read_data1
);

  dbg_state_t              state;
  logic [REG_SEL_BITS-1:0] sel_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [REG_SEL_BITS-1:0] cnt;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_err;
  logic                    dbg_wr;

  // A debug write only ever occupies a cycle the core left free.
  assign dbg_wr = !core_wEn &&
                  ((state == ST_WRITE && sel_q != '0) || state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      data_q    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dbg_req_valid) begin
            sel_q  <= dbg_req_sel;
            data_q <= dbg_req_data;
            case (dbg_req_op)
              OP_READ:  state <= ST_READ;
              OP_WRITE: state <= ST_WRITE;
              OP_CLEAR: begin
                state <= ST_CLEAR;
                cnt   <= REG_SEL_BITS'(1);
              end
              default: begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        ST_READ: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= rf_read_data1;
          rsp_err   <= 1'b0;
        end

        ST_WRITE: begin
          if (sel_q == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else if (!core_wEn) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= data_q;
            rsp_err   <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // Terminal compare on all-ones keeps the counter from wrapping back to x0.
          if (!core_wEn) begin
            if (cnt == '1) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= DATA_WIDTH'(cnt);
              rsp_err   <= 1'b0;
            end else begin
              cnt <= cnt + REG_SEL_BITS'(1);
            end
          end
        end

        ST_RESP: begin
          if (dbg_rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_rsp_valid = rsp_valid;
  assign dbg_rsp_data  = rsp_data;
  assign dbg_rsp_err   = rsp_err;

  // Register-file ports are forced quiet while reset is held.
  always_comb begin
    dbg_req_ready = 1'b0;
    rf_wEn        = 1'b0;
    rf_write_sel  = '0;
    rf_write_data = '0;
    rf_read1_sel  = '0;
    if (reset) begin
      dbg_req_ready = (state == ST_IDLE);
      if (dbg_wr) begin
        rf_wEn        = 1'b1;
        rf_write_sel  = (state == ST_CLEAR) ? cnt : sel_q;
        rf_write_data = (state == ST_CLEAR) ? '0 : data_q;
      end else begin
        rf_wEn        = core_wEn;
        rf_write_sel  = core_write_sel;
        rf_write_data = core_write_data;
      end
      rf_read1_sel = (state == ST_READ) ? sel_q : core_read1_sel;
    end
  end

endmodule

// File: doc/regfile_debug_port.md
# regfile_debug_port

Debug-side access controller for the integer register file. Accepts read, write and clear-all commands over a valid/ready request channel and drives the register file's write port and read port 1. Returns one response per command over a valid/ready response channel. Sits between the core's writeback/decode stage and `regFile`; core writeback always has priority on the write port.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: register width.
- `REG_SEL_BITS`, 5: register index width; the file holds 2^REG_SEL_BITS entries.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `core_wEn`, in, 1: core writeback enable.
- `core_write_sel`, in, REG_SEL_BITS: core writeback index.
- `core_write_data`, in, DATA_WIDTH: core writeback data.
- `core_read1_sel`, in, REG_SEL_BITS: core read port 1 index.
- `dbg_req_valid`, in, 1: request valid.
- `dbg_req_ready`, out, 1: request ready.
- `dbg_req_op`, in, 2: opcode. 00 = read, 01 = write, 10 = clear-all, 11 = reserved.
- `dbg_req_sel`, in, REG_SEL_BITS: target register.
- `dbg_req_data`, in, DATA_WIDTH: write data.
- `dbg_rsp_valid`, out, 1: response valid.
- `dbg_rsp_ready`, in, 1: response ready.
- `dbg_rsp_data`, out, DATA_WIDTH: response data.
- `dbg_rsp_err`, out, 1: response error flag.
- `rf_wEn`, out, 1: write enable to the register file.
- `rf_write_sel`, out, REG_SEL_BITS: write index to the register file.
- `rf_write_data`, out, DATA_WIDTH: write data to the register file.
- `rf_read1_sel`, out, REG_SEL_BITS: read port 1 index to the register file.
- `rf_read_data1`, in, DATA_WIDTH: register file read data. This is a combinational function of `rf_read1_sel`.

## Operation

**States:** IDLE, READ, WRITE, CLEAR, RESP.

**IDLE**
- `dbg_req_ready` = 1.
- A handshake occurs when `valid` and `ready` are both high. On handshake, latch op, sel and data.
- Next state: op 00 → READ; op 01 → WRITE; op 10 → CLEAR; op 11 → RESP with err = 1 and data = 0.

**READ** (one cycle)
- `rf_read1_sel` = latched sel.
- Register `rf_read_data1` into `dbg_rsp_data` with err = 0, then go to RESP.
- Reading x0 returns whatever the register file returns for x0, which is 0.

**WRITE**
- If latched sel = 0: no write is issued; go to RESP with err = 1 and data = 0.
- Else, if `core_wEn` = 1: stall in WRITE.
- Else: drive `rf_wEn` = 1 with the latched sel and data; go to RESP with data = written value and err = 0.

**CLEAR**
- An index counter starts at 1.
- Each cycle with `core_wEn` = 0: write 0 to the counter index, then increment.
- Any cycle with `core_wEn` = 1: stall; the counter holds.
- After writing index 2^REG_SEL_BITS − 1, go to RESP with data = 2^REG_SEL_BITS − 1 (31 by default) and err = 0.

**RESP**
- `dbg_rsp_valid` = 1, with data and err held stable.
- On handshake with `dbg_rsp_ready`, return to IDLE.
- `dbg_req_ready` = 0 in every state except IDLE.

**Write-port mux**
- Whenever the FSM is not issuing a debug write, `rf_wEn`, `rf_write_sel` and `rf_write_data` are combinational copies of the core signals.
- A debug write is never issued in a cycle where `core_wEn` = 1, so the core write is never dropped.

**Read-port mux**
- `rf_read1_sel` = `core_read1_sel` except in READ. The core must be halted during debug reads; this is not checked.

## Timing

**Reset** (`reset` low at a clock edge)
- Next state is IDLE and the counter clears to 0.
- `dbg_rsp_valid`, `dbg_rsp_data` and `dbg_rsp_err` are 0.
- While `reset` is low: `dbg_req_ready` = 0, `rf_wEn` = 0, and `rf_write_sel`, `rf_write_data` and `rf_read1_sel` = 0.
- Reset mid-command abandons the command with no response. Registers already cleared stay cleared.

**Latency** (request handshake at cycle N, no stalls)
- Read: `dbg_rsp_valid` rises at N+2.
- Write: the register-file write edge ends cycle N+1; `dbg_rsp_valid` rises at N+2.
- Clear-all: 31 write cycles (N+1 … N+31); `dbg_rsp_valid` rises at N+32.
- Each cycle with `core_wEn` high during WRITE or CLEAR adds one cycle.

**Throughput and backpressure**
- At most one outstanding command.
- A new request is accepted no earlier than the cycle after the response handshake.
- Response backpressure is unbounded; data is held until accepted.

## Structure

- Shared package `regfile_dbg_pkg`: opcode constants (OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD) and the state encoding.
- Single flat module; no sub-module is needed.
- The clear counter is REG_SEL_BITS wide. It terminates on an all-ones compare, so it never wraps.

## Test plan

- **Write then read:** write x5 = 0xA (idle core), then read x5 → first response data 0xA, err 0 at N+2; read response data 0xA.
- **Write to x0:** write x0 = 0x7 → response err 1, data 0, `rf_wEn` never asserted by debug; a following read of x0 returns 0.
- **Core priority:** hold `core_wEn` = 1 for 3 cycles during a debug write to x3 = 0x5 → the core writes pass through unchanged, the debug write lands after them, and the response arrives 3 cycles late.
- **Clear-all:** preload x1 = 2, x7 = 9, x31 = 0xFFFFFFFF, then clear → response data 31 at N+32; subsequent reads of x1, x7 and x31 return 0.
- **Response backpressure and reserved op:** op 11 with `dbg_rsp_ready` = 0 for 5 cycles → `dbg_rsp_valid` held, err 1 stable, `dbg_req_ready` = 0 throughout; the next request is accepted only after the response handshake.
- **Reset mid-clear:** drive `reset` low at N+10 of a clear → no response, state IDLE; x1–x9 read 0, x10 retains its prior value after reset release (register-file reset excluded).
